// File: rtl/trace_pkg.sv
// Shared types for the commit trace capture block.
//   trace_kind_t : record type carried on out_kind
//   trace_rec_t  : record layout at the default 16-bit timestamp width
//   DROP_MAX     : saturation value of the drop counter
package trace_pkg;

   typedef enum logic [1:0] {
      TR_REG     = 2'd0,
      TR_MEM_WR  = 2'd1,
      TR_MEM_RD  = 2'd2,
      TR_MEM_ERR = 2'd3
   } trace_kind_t;

   localparam int TS_W_DEF = 16;

   typedef struct packed {
      trace_kind_t           kind;
      logic [8:0]            idx;
      logic [31:0]           data;
      logic [TS_W_DEF-1:0]   ts;
   } trace_rec_t;

   localparam logic [15:0] DROP_MAX = 16'hFFFF;

endpackage

// File: rtl/commit_trace_capture_if.sv
// Observation and trace-stream bundle between the core, the capture block
// and the downstream logger.
//   master : core/logger side -- drives observations and out_ready
//   slave  : capture block    -- consumes observations, presents records
interface commit_trace_capture_if #(
   parameter int TS_W = 16
);
   logic                    reg_write_sig;
   logic [4:0]              reg_num;
   logic [31:0]             reg_data;
   logic                    wr;
   logic                    rd;
   logic [8:0]              addr;
   logic [31:0]             wr_data;
   logic [31:0]             rd_data;

   logic                    out_valid;
   logic                    out_ready;
   trace_pkg::trace_kind_t  out_kind;
   logic [8:0]              out_idx;
   logic [31:0]             out_data;
   logic [TS_W-1:0]         out_ts;

   modport master (
      output reg_write_sig, reg_num, reg_data, wr, rd, addr, wr_data, rd_data,
      output out_ready,
      input  out_valid, out_kind, out_idx, out_data, out_ts
   );

   modport slave (
      input  reg_write_sig, reg_num, reg_data, wr, rd, addr, wr_data, rd_data,
      input  out_ready,
      output out_valid, out_kind, out_idx, out_data, out_ts
   );
endinterface

// File: rtl/trace_fifo_2w1r.sv
// First-word fall-through FIFO with two write ports and one read port.
//   clk, reset     : clock, async active-low reset (empties the FIFO)
//   push0, din0    : first write of the cycle
//   push1, din1    : second write, lands behind din0; only used with push0
//   pop            : consume the head entry
//   dout, valid    : head entry (zero when empty), non-empty flag
//   count          : occupancy, 0..DEPTH
// The caller guarantees pushes never exceed the free space.
module trace_fifo_2w1r #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push0,
   input  logic                   push1,
   input  logic [W-1:0]           din0,
   input  logic [W-1:0]           din1,
   input  logic                   pop,
   output logic [W-1:0]           dout,
   output logic                   valid,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_addr1;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pop_ok;

   always_comb begin
      pop_ok   = pop && (count_q != '0);
      wr_addr1 = wr_ptr_q + PTR_W'(1);
      wr_ptr_d = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
      count_d  = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop_ok);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push0) mem_q[wr_ptr_q] <= din0;
      if (push1) mem_q[wr_addr1] <= din1;
   end

   assign valid = (count_q != '0);
   assign dout  = valid ? mem_q[rd_ptr_q] : '0;
   assign count = count_q;

endmodule

// File: rtl/commit_trace_capture.sv
// Synthesizable commit trace capture. Turns per-cycle register writeback
// and data-memory observations into timestamped records and streams them
// out over valid/ready.
//   clk, reset : clock, async active-low reset
//   tif        : observation inputs and record output stream (slave side)
//   overflow   : sticky, set once any record has been dropped
//   drop_cnt   : saturating number of dropped records
module commit_trace_capture
   import trace_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int TS_W      = 16,
   parameter bit FILTER_X0 = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   commit_trace_capture_if.slave  tif,
   output logic                   overflow,
   output logic [15:0]            drop_cnt
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      trace_kind_t      kind;
      logic [8:0]       idx;
      logic [31:0]      data;
      logic [TS_W-1:0]  ts;
   } rec_t;

   localparam int REC_W = $bits(rec_t);

   logic [TS_W-1:0]  ts_q, ts_d;
   logic             overflow_q, overflow_d;
   logic [15:0]      drop_cnt_q, drop_cnt_d;

   logic             reg_ev, mem_ev;
   trace_kind_t      mem_kind;
   rec_t             reg_rec, mem_rec, rec0, rec1, head;
   logic [REC_W-1:0] head_bits;
   logic [1:0]       n_ev, n_drop;
   logic             push0, push1, pop, fifo_valid;
   logic [CNT_W-1:0] count, free;
   logic [16:0]      drop_sum;

   always_comb begin
      reg_ev = tif.reg_write_sig && !(FILTER_X0 && (tif.reg_num == 5'd0));
      mem_ev = tif.wr || tif.rd;

      if (tif.wr && tif.rd) mem_kind = TR_MEM_ERR;
      else if (tif.wr)      mem_kind = TR_MEM_WR;
      else                  mem_kind = TR_MEM_RD;

      reg_rec = '{kind: TR_REG, idx: {4'd0, tif.reg_num}, data: tif.reg_data, ts: ts_q};
      mem_rec = '{kind: mem_kind, idx: tif.addr,
                  data: (tif.rd && !tif.wr) ? tif.rd_data : tif.wr_data, ts: ts_q};

      n_ev = {1'b0, reg_ev} + {1'b0, mem_ev};

      // A pop in this cycle makes its slot available to this cycle's pushes.
      pop  = fifo_valid && tif.out_ready;
      free = CNT_W'(DEPTH) - count + CNT_W'(pop);

      // Writeback belongs to the older instruction, so the reg record always
      // takes the first slot; with one slot left the mem record is the one lost.
      push0  = (n_ev != 2'd0) && (free != '0);
      push1  = (n_ev == 2'd2) && (free >= CNT_W'(2));
      rec0   = reg_ev ? reg_rec : mem_rec;
      rec1   = mem_rec;
      n_drop = n_ev - {1'b0, push0} - {1'b0, push1};

      ts_d       = ts_q + TS_W'(1);
      overflow_d = overflow_q || (n_drop != 2'd0);
      drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
      drop_cnt_d = (drop_sum > {1'b0, DROP_MAX}) ? DROP_MAX : drop_sum[15:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ts_q       <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         ts_q       <= ts_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   trace_fifo_2w1r #(
      .DEPTH (DEPTH),
      .W     (REC_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push0 (push0),
      .push1 (push1),
      .din0  (rec0),
      .din1  (rec1),
      .pop   (pop),
      .dout  (head_bits),
      .valid (fifo_valid),
      .count (count)
   );

   assign head          = rec_t'(head_bits);
   assign tif.out_valid = fifo_valid;
   assign tif.out_kind  = head.kind;
   assign tif.out_idx   = head.idx;
   assign tif.out_data  = head.data;
   assign tif.out_ts    = head.ts;
   assign overflow      = overflow_q;
   assign drop_cnt      = drop_cnt_q;

endmodule
